// File: rtl/condicionador_botoes.sv
// Push-button conditioner: per-channel two-flop synchroniser plus counter debounce.
// Emits one pulse per accepted press; a simultaneous executar press is deferred one cycle.
module condicionador_botoes #(
    parameter int LIMITE_DEBOUNCE  = 1000000,
    parameter int LARGURA_CONTADOR = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_n,
    output logic       pulso_push,
    output logic       pulso_executar,
    output logic       nivel_push,
    output logic       nivel_executar,
    output logic       ocupado
);

    localparam logic [LARGURA_CONTADOR-1:0] CNT_TC = LARGURA_CONTADOR'(LIMITE_DEBOUNCE - 1);

    logic [1:0]                        s1_q, s2_q;
    logic [1:0]                        est_q, est_d;
    logic [1:0][LARGURA_CONTADOR-1:0]  cnt_q, cnt_d;
    logic                              pendente_q, pendente_d;
    logic                              pulso_push_q, pulso_push_d;
    logic                              pulso_exec_q, pulso_exec_d;
    logic                              ocupado_q, ocupado_d;
    logic [1:0]                        evt, press;

    always_comb begin
        est_d = est_q;
        cnt_d = cnt_q;
        evt   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == est_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TC) begin
                est_d[i] = s2_q[i];
                cnt_d[i] = '0;
                evt[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end

        // Only accepted falling levels (presses) produce pulses; releases just update est.
        press        = evt & ~s2_q;
        pulso_push_d = press[0];
        pulso_exec_d = (press[1] & ~press[0]) | pendente_q;
        pendente_d   = press[1] & press[0];
        ocupado_d    = (|cnt_q[0]) | (|cnt_q[1]) | pendente_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q         <= 2'b11;
            s2_q         <= 2'b11;
            est_q        <= 2'b11;
            cnt_q        <= '0;
            pendente_q   <= 1'b0;
            pulso_push_q <= 1'b0;
            pulso_exec_q <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            s1_q         <= key_n;
            s2_q         <= s1_q;
            est_q        <= est_d;
            cnt_q        <= cnt_d;
            pendente_q   <= pendente_d;
            pulso_push_q <= pulso_push_d;
            pulso_exec_q <= pulso_exec_d;
            ocupado_q    <= ocupado_d;
        end
    end

    assign pulso_push     = pulso_push_q;
    assign pulso_executar = pulso_exec_q;
    assign nivel_push     = ~est_q[0];
    assign nivel_executar = ~est_q[1];
    assign ocupado        = ocupado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes with LIMITE_DEBOUNCE=4: expected pulses are queued
// with the edge they must appear after, and popped as the DUT reaches that edge.
module tb_condicionador_botoes;

    localparam int LIM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_n;
    logic       pulso_push, pulso_executar, nivel_push, nivel_executar, ocupado;

    typedef struct {
        int         ed;
        logic [1:0] kind;
    } exp_t;

    exp_t sb_q[$];
    int   edge_n  = 0;
    int   n_total = 0;
    int   n_bad   = 0;

    condicionador_botoes #(
        .LIMITE_DEBOUNCE  (LIM),
        .LARGURA_CONTADOR (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_n          (key_n),
        .pulso_push     (pulso_push),
        .pulso_executar (pulso_executar),
        .nivel_push     (nivel_push),
        .nivel_executar (nivel_executar),
        .ocupado        (ocupado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_total++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (edge %0d)", tag, obs, exp_v, edge_n);
        end
    endtask

    task automatic expect_pulse(input int ed, input logic [1:0] kind);
        exp_t e;
        e.ed   = ed;
        e.kind = kind;
        sb_q.push_back(e);
    endtask

    // kind bit 0 = pulso_push, bit 1 = pulso_executar
    task automatic monitor();
        logic [1:0] got;
        exp_t       e;
        got = {pulso_executar, pulso_push};
        if (sb_q.size() > 0 && sb_q[0].ed == edge_n) begin
            e = sb_q.pop_front();
            chk("pulse", int'(got), int'(e.kind));
        end else if (got != 2'b00) begin
            chk("spurious_pulse", int'(got), 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        monitor();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, er;

        rst   = 1'b0;
        key_n = 2'b11;
        run(3);
        chk("rst_pulso_push", pulso_push, 0);
        chk("rst_pulso_exec", pulso_executar, 0);
        chk("rst_nivel_push", nivel_push, 0);
        chk("rst_nivel_exec", nivel_executar, 0);
        chk("rst_ocupado", ocupado, 0);
        rst = 1'b1;
        run(3);

        // clean press of KEY[0]
        key_n = 2'b10;
        e0 = edge_n + 1;
        expect_pulse(e0 + LIM + 1, 2'b01);
        run(LIM + 1);
        chk("clean_nivel_before", nivel_push, 0);
        tick();
        chk("clean_nivel_after", nivel_push, 1);
        chk("clean_nivel_exec", nivel_executar, 0);
        run(5);
        key_n = 2'b11;
        run(10);
        chk("clean_release_nivel", nivel_push, 0);

        // bounce 0,1,0,1 then held low
        key_n = 2'b10; tick();
        key_n = 2'b11; tick();
        key_n = 2'b10; tick();
        key_n = 2'b11; tick();
        key_n = 2'b10;
        e0 = edge_n + 1;
        expect_pulse(e0 + LIM + 1, 2'b01);
        run(12);
        chk("bounce_nivel", nivel_push, 1);
        key_n = 2'b11;
        run(10);

        // hold 50 cycles then release: level drops, no pulse on release
        key_n = 2'b10;
        e0 = edge_n + 1;
        expect_pulse(e0 + LIM + 1, 2'b01);
        run(50);
        key_n = 2'b11;
        er = edge_n + 1;
        run(LIM + 1);
        chk("hold_nivel_before_drop", nivel_push, 1);
        tick();
        chk("hold_nivel_after_drop", nivel_push, 0);
        run(5);
        chk("hold_queue_drained", sb_q.size(), 0);

        // simultaneous press: push first, executar one cycle later
        key_n = 2'b00;
        e0 = edge_n + 1;
        expect_pulse(e0 + LIM + 1, 2'b01);
        expect_pulse(e0 + LIM + 2, 2'b10);
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("simul_ocupado", ocupado, int'(edge_n >= e0 + 3 && edge_n <= e0 + 6));
        end
        chk("simul_nivel_exec", nivel_executar, 1);
        key_n = 2'b11;
        run(10);
        chk("simul_release_ocupado", ocupado, 0);

        // reset asserted mid-debounce of KEY[1]
        key_n = 2'b01;
        e0 = edge_n + 1;
        run(4);
        chk("rstmid_ocupado_pre", ocupado, 1);
        rst = 1'b0;
        #1;
        chk("rstmid_ocupado", ocupado, 0);
        chk("rstmid_nivel_exec", nivel_executar, 0);
        chk("rstmid_pulso_exec", pulso_executar, 0);
        run(2);
        rst = 1'b1;
        er = edge_n + 1;
        expect_pulse(er + LIM + 1, 2'b10);
        run(LIM + 2);
        chk("rstmid_nivel_after", nivel_executar, 1);
        key_n = 2'b11;
        run(10);

        // glitch of LIM-1 low samples: rejected
        key_n = 2'b10;
        run(LIM - 1);
        key_n = 2'b11;
        run(12);
        chk("glitch_nivel", nivel_push, 0);
        chk("glitch_ocupado", ocupado, 0);

        // exactly LIM low samples: accepted
        key_n = 2'b10;
        e0 = edge_n + 1;
        expect_pulse(e0 + LIM + 1, 2'b01);
        run(LIM);
        key_n = 2'b11;
        run(12);
        chk("minpress_ocupado", ocupado, 0);

        chk("final_queue_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
- Upstream input-conditioning stage for the RPN calculator datapath.
- Takes the raw active-low KEY[1:0] push-buttons asynchronous to the clock, then synchronises and debounces them.
- Emits exactly one single-cycle pulse per physical press: pulso_push from KEY[0], pulso_executar from KEY[1].
- These pulses replace the direct inverters currently feeding push_pilha / executar_operacao of the RPN system.

Parameters:
- LIMITE_DEBOUNCE, default 1000000: consecutive cycles a new synchronised level must persist before being accepted (20 ms at 50 MHz). Legal range is 2 to 2^LARGURA_CONTADOR-1.
- LARGURA_CONTADOR, default 20: width of each per-channel debounce counter.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- rst  input  1  asynchronous active-low reset (0 = reset).
- key_n  input  2  raw buttons, active-low. Bit 0 = push, bit 1 = executar.
- pulso_push  output  1  one-cycle high pulse per debounced KEY[0] press.
- pulso_executar  output  1  one-cycle high pulse per debounced KEY[1] press.
- nivel_push  output  1  debounced pressed level of KEY[0] (1 = held).
- nivel_executar  output  1  debounced pressed level of KEY[1] (1 = held).
- ocupado  output  1  high while any debounce counter is non-zero or an executar pulse is pending.

Behaviour:
- Clock and reset:
  - One clock: clk. Reset rst is asynchronous, active-low.
  - All flops update on the rising edge of clk.
  - While rst=0, and immediately when it falls: sync flops and stable registers = 1 (released), counters = 0, pendente = 0.
  - While rst=0, all outputs are 0: pulso_push, pulso_executar, nivel_push, nivel_executar, ocupado.
- Per channel i, synchronisation: two-flop synchroniser s1[i] <= key_n[i], s2[i] <= s1[i].
- Per channel i, debounce. The stable register est[i] holds the accepted level. Each edge:
  - if s2[i] == est[i]: cnt[i] <= 0;
  - else if cnt[i] == LIMITE_DEBOUNCE-1: est[i] <= s2[i], cnt[i] <= 0, and the event evt[i] is raised combinationally for this edge;
  - else: cnt[i] <= cnt[i]+1.
- Glitch rejection: a disagreeing run shorter than LIMITE_DEBOUNCE cycles clears cnt and never changes est.
- Only press events generate pulses: evt with s2=0. Release events (s2=1) update est only.
- nivel_* = ~est, registered, no extra latency.
- Latency, KEY[0]:
  - key_n[0] is first sampled low at edge 0.
  - s2 goes low after edge 1; cnt counts edges 2 to LIMITE_DEBOUNCE.
  - est falls at edge LIMITE_DEBOUNCE+1; pulso_push is registered high at that same edge.
  - pulso_push is high for exactly the cycle between edges LIMITE_DEBOUNCE+1 and LIMITE_DEBOUNCE+2, then 0.
- pulso_executar follows the same timing rule, except in the simultaneous case below.
- Simultaneous press events in the same edge:
  - pulso_push is issued at that edge; pendente <= 1.
  - pulso_executar is issued at the next edge; pendente <= 0.
  - The two pulses are never high in the same cycle.
  - Because LIMITE_DEBOUNCE >= 2, no second executar event can arrive while pendente=1.
- Holding a key produces a single pulse, no auto-repeat. The next pulse requires an accepted release followed by an accepted press.
- Reset released while a key is held: est restarts at released, so one pulse is produced after the full latency above.
- Reset asserted mid-debounce: the count is discarded and no pulse is produced.
- ocupado = |cnt[0] or |cnt[1] or pendente, registered.

Test Plan:
All scenarios use LIMITE_DEBOUNCE=4.
- Clean press: key_n=2'b10 held from edge 0 -> pulso_push=1 only in the cycle after edge 5, nivel_push=1 from edge 5, pulso_executar stays 0.
- Bounce: key_n[0] toggles 0,1,0,1 on consecutive edges, then is held 0 -> no pulse during the toggling; exactly one pulso_push 6 cycles after the final falling sample.
- Hold and release: key_n[0] low for 50 cycles, then high -> exactly one pulso_push. nivel_push drops 5 edges after the release is sampled. No pulse on release.
- Simultaneous: key_n 2'b11 -> 2'b00 at edge 0 -> pulso_push in the cycle after edge 5, pulso_executar in the cycle after edge 6, never overlapping. ocupado=1 from edge 3 through edge 6.
- Reset mid-debounce: press KEY[1], assert rst=0 at edge 3 for 2 cycles, keep key held -> outputs go to 0 immediately. After rst=1, one pulso_executar appears at the full latency counted from the first post-reset sample.
- Short glitch: key_n[0] low for 3 cycles, then high -> no pulse, nivel_push stays 0, ocupado returns to 0.
